// File: rtl/pairwise_eq_matrix.sv
`default_nettype none
// ============================================================================
// Module   : pairwise_eq_matrix
// Brief    : 5x5 pairwise equality matrix of a..e, plus registered copy and
//            all-equal flag. Optional stats outputs behind PAIR_EQ_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pairwise_eq_matrix (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a,
   input  logic        b,
   input  logic        c,
   input  logic        d,
   input  logic        e,
   output logic [24:0] out,
   output logic [24:0] out_q,
   output logic        all_eq
`ifdef PAIR_EQ_STATS_EN
   ,
   output logic [4:0]  match_cnt,
   output logic        majority
`endif
);

   localparam int          c_N        = 5;
   localparam logic [24:0] c_ALL_ONES = 25'h1FF_FFFF;

   logic [c_N-1:0] w_x;
   assign w_x = {e, d, c, b, a};

   // Row i holds x_i compared against x0..x4, row 0 in the MSBs.
   generate
      for (genvar i = 0; i < c_N; i++) begin : g_row
         for (genvar j = 0; j < c_N; j++) begin : g_col
            assign out[24 - 5*i - j] = ~(w_x[i] ^ w_x[j]);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q  <= '0;
         all_eq <= 1'b0;
      end else begin
         out_q  <= out;
         all_eq <= (out == c_ALL_ONES);
      end
   end

`ifdef PAIR_EQ_STATS_EN
   logic [4:0] w_pop;
   logic [2:0] w_ones;

   always_comb begin
      w_pop  = '0;
      w_ones = '0;
      for (int k = 0; k < 25; k++) begin
         w_pop = w_pop + {4'b0, out[k]};
      end
      for (int k = 0; k < c_N; k++) begin
         w_ones = w_ones + {2'b0, w_x[k]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         match_cnt <= '0;
         majority  <= 1'b0;
      end else begin
         match_cnt <= w_pop;
         majority  <= (w_ones >= 3'd3);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pairwise_eq_matrix.sv
`default_nettype none
// ============================================================================
// Module   : tb_pairwise_eq_matrix
// Brief    : Randomized self-checking bench for pairwise_eq_matrix.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pairwise_eq_matrix;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a, b, c, d, e;
   logic [24:0] out, out_q;
   logic        all_eq;
`ifdef PAIR_EQ_STATS_EN
   logic [4:0]  match_cnt;
   logic        majority;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   pairwise_eq_matrix dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .c      (c),
      .d      (d),
      .e      (e),
      .out    (out),
      .out_q  (out_q),
      .all_eq (all_eq)
`ifdef PAIR_EQ_STATS_EN
      ,
      .match_cnt (match_cnt),
      .majority  (majority)
`endif
   );

   always #5 clk = ~clk;

   // v[4] is a, v[0] is e; bit (24-5i-j) is 1 when operands i and j are equal.
   function automatic logic [24:0] model(input logic [4:0] v);
      logic [24:0] m;
      m = '0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            m[24 - 5*i - j] = (v[4-i] == v[4-j]);
      return m;
   endfunction

   task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input logic [4:0] v);
      {a, b, c, d, e} = v;
   endtask

   // Apply v at negedge, check out, then check registered outputs after posedge.
   task automatic cycle(input string tag, input logic [4:0] v);
      @(negedge clk);
      drive(v);
      #1 check({tag, "_out"}, out, model(v));
      @(posedge clk);
      #1;
      check({tag, "_out_q"}, out_q, rst_n ? model(v) : 25'h0);
      check({tag, "_all_eq"}, {24'b0, all_eq},
            {24'b0, rst_n && (v == 5'b00000 || v == 5'b11111)});
`ifdef PAIR_EQ_STATS_EN
      check({tag, "_cnt"}, {20'b0, match_cnt}, rst_n ? 25'($countones(model(v))) : 25'h0);
      check({tag, "_maj"}, {24'b0, majority}, {24'b0, rst_n && ($countones(v) >= 3)});
`endif
   endtask

   initial begin
      logic [4:0] v;
      rst_n = 1'b0;
      drive(5'b00000);

      // Reset held two clocks with toggling inputs.
      cycle("rst0", 5'b10110);
      cycle("rst1", 5'b01001);
      rst_n = 1'b1;

      cycle("zeros", 5'b00000);
      check("zeros_const", out_q, 25'h1FF_FFFF);

      cycle("a_only", 5'b10000);
      check("a_only_const", out_q, 25'h107_BDEF);

      cycle("alt", 5'b10101);
      check("alt_pop", 25'($countones(out)), 25'd13);

      // Reset asserted mid-run clears at that edge, resumes after release.
      rst_n = 1'b0;
      cycle("midrst", 5'b11111);
      rst_n = 1'b1;
      cycle("ones", 5'b11111);
      check("ones_const", out, 25'h1FF_FFFF);

      // Random vectors changed on both clock edges.
      for (int k = 0; k < 100; k++) begin
         v = 5'($urandom);
         cycle("rnd", v);
         v = 5'($urandom);
         drive(v);
         #1 check("rnd_pos_out", out, model(v));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
